// File: rtl/phase_meas_sched.sv
// Round-robin scheduler sharing one delay/period measurement engine
// across N_CH asynchronous square-wave channel pairs.
module phase_meas_sched #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1_000_000,
  localparam int IW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_req,
  input  logic [N_CH-1:0]  sq_ref,
  input  logic [N_CH-1:0]  sq_meas,
  output logic [N_CH-1:0]  ch_grant,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IW-1:0]    res_ch,
  output logic [CNT_W-1:0] res_delay,
  output logic [CNT_W-1:0] res_period,
  output logic             res_timeout
);

  typedef enum logic [2:0] {
    IDLE, WAIT_REF, MEAS, PERIOD, DONE
  } state_t;

  state_t state, state_n;

  logic [N_CH-1:0] ref_s1, ref_s2, ref_s3;
  logic [N_CH-1:0] meas_s1, meas_s2, meas_s3;
  logic [N_CH-1:0] ref_pls, meas_pls;

  logic [IW-1:0]    ptr, ptr_n, sel, idx;
  logic             found;
  logic [N_CH-1:0]  grant_oh;
  logic             grant_go;
  logic             rp, mp;

  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] tmo, tmo_n, tmo_inc;
  logic             tmo_hit;
  logic [CNT_W-1:0] delay_n, period_n;
  logic             tout_n;

  // Third stage only remembers the previous level for edge detection,
  // so ref and meas see exactly the same latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_s1  <= '0;
      ref_s2  <= '0;
      ref_s3  <= '0;
      meas_s1 <= '0;
      meas_s2 <= '0;
      meas_s3 <= '0;
    end else begin
      ref_s1  <= sq_ref;
      ref_s2  <= ref_s1;
      ref_s3  <= ref_s2;
      meas_s1 <= sq_meas;
      meas_s2 <= meas_s1;
      meas_s3 <= meas_s2;
    end
  end

  assign ref_pls  = ref_s2 & ~ref_s3;
  assign meas_pls = meas_s2 & ~meas_s3;

  assign rp = ref_pls[res_ch];
  assign mp = meas_pls[res_ch];

  // Cyclic search; walking backwards leaves the lowest offset in sel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N_CH);
      if (ch_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    grant_oh      = '0;
    grant_oh[sel] = 1'b1;
  end

  assign ptr_n = (sel == IW'(N_CH - 1)) ? '0 : sel + 1'b1;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign tmo_inc = (tmo == '1) ? tmo : tmo + 1'b1;
  assign tmo_hit = (tmo == CNT_W'(TIMEOUT - 1));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tmo_n    = tmo;
    delay_n  = res_delay;
    period_n = res_period;
    tout_n   = res_timeout;
    grant_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && found) begin
          grant_go = 1'b1;
          cnt_n    = '0;
          tmo_n    = '0;
          tout_n   = 1'b0;
          state_n  = WAIT_REF;
        end
      end
      WAIT_REF, MEAS, PERIOD: begin
        cnt_n = cnt_inc;
        tmo_n = tmo_inc;
        if (!enable) begin
          state_n = IDLE;
        end else if (tmo_hit) begin
          delay_n  = '0;
          period_n = '0;
          tout_n   = 1'b1;
          state_n  = DONE;
        end else if (state == WAIT_REF) begin
          // cnt holds (current cycle - T0) once the ref edge is seen
          if (rp) begin
            cnt_n = CNT_W'(1);
            if (mp) begin
              delay_n = '0;
              state_n = PERIOD;
            end else begin
              state_n = MEAS;
            end
          end
        end else if (state == MEAS) begin
          if (mp) begin
            delay_n = cnt;
            if (rp) begin
              period_n = cnt;
              state_n  = DONE;
            end else begin
              state_n  = PERIOD;
            end
          end else if (rp) begin
            delay_n  = cnt;
            period_n = cnt;
            state_n  = DONE;
          end
        end else begin
          if (rp) begin
            period_n = cnt;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr         <= '0;
      cnt         <= '0;
      tmo         <= '0;
      ch_grant    <= '0;
      res_ch      <= '0;
      res_delay   <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      tmo         <= tmo_n;
      res_delay   <= delay_n;
      res_period  <= period_n;
      res_timeout <= tout_n;
      res_valid   <= (state_n == DONE);
      if (grant_go) begin
        ch_grant <= grant_oh;
        res_ch   <= sel;
        ptr      <= ptr_n;
      end else if (state_n == IDLE) begin
        ch_grant <= '0;
      end
    end
  end

endmodule

// File: doc/phase_meas_sched.md
PHASE_MEAS_SCHED -- requirements
Module: phase_meas_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of square-wave channel pairs sharing one measurement engine.
REQ-002 SHALL have parameter CNT_W, default 32: width of the delay, period and timeout counters.
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000: maximum clk cycles allowed per measurement.
REQ-004 SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: permits new grants.
REQ-007 SHALL have port ch_req, input, N_CH bits: per-channel measurement request, level-sensitive.
REQ-008 SHALL have port sq_ref, input, N_CH bits: reference square waves, asynchronous to clk.
REQ-009 SHALL have port sq_meas, input, N_CH bits: measured square waves, asynchronous to clk.
REQ-010 SHALL have port ch_grant, output, N_CH bits: one-hot grant for the channel being measured.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port res_valid, output, 1 bit: a result is available.
REQ-013 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port res_ch, output, $clog2(N_CH) bits: channel index of the result.
REQ-015 SHALL have port res_delay, output, CNT_W bits: cycles from the ref rising edge to the meas rising edge.
REQ-016 SHALL have port res_period, output, CNT_W bits: cycles between consecutive ref rising edges.
REQ-017 SHALL have port res_timeout, output, 1 bit: the measurement was aborted by timeout.

Function
REQ-018 SHALL pass every sq_ref and sq_meas bit through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse; ref and meas paths SHALL have identical latency.
REQ-019 SHALL implement states IDLE, WAIT_REF, MEAS, PERIOD and DONE.
REQ-020 IDLE: when enable=1 and ch_req!=0, SHALL grant the lowest-index requester at or after the round-robin pointer (cyclic search), set ch_grant/res_ch, set pointer to (grant+1) mod N_CH, clear the timeout counter, and go to WAIT_REF.
REQ-021 WAIT_REF: on the selected ref edge pulse (cycle T0) SHALL go to MEAS with the cycle counter at 0.
REQ-022 MEAS: SHALL latch res_delay = cycle of the first selected meas pulse minus T0, then go to PERIOD; a meas pulse at T0 SHALL give res_delay=0.
REQ-023 PERIOD: on the next ref pulse SHALL latch res_period = pulse cycle minus T0, then go to DONE with res_timeout=0.
REQ-024 If a ref pulse arrives in MEAS before any meas pulse, SHALL set res_delay=res_period=that cycle minus T0, then go to DONE.
REQ-025 The cycle counter SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 SHALL count cycles in WAIT_REF, MEAS and PERIOD; when the count reaches TIMEOUT, SHALL go to DONE with res_timeout=1 and res_delay=res_period=0.
REQ-027 DONE: res_valid=1; res_ch, res_delay, res_period and res_timeout SHALL stay stable until the cycle res_valid and res_ready are both high, then go to IDLE with ch_grant=0 and res_valid=0.
REQ-028 The earliest next grant SHALL be the cycle after the handshake; there is no back-to-back grant in the handshake cycle.
REQ-029 enable=0 in WAIT_REF, MEAS or PERIOD SHALL abort to IDLE next cycle with no result; in DONE, enable SHALL be ignored.
REQ-030 Deasserting ch_req after a grant SHALL NOT affect the measurement in progress.
REQ-031 Non-selected channel edges SHALL be ignored.

Reset
REQ-032 While rstn=0: state=IDLE, pointer=0, synchronizers and counters at 0, and all outputs (ch_grant, busy, res_valid, res_ch, res_delay, res_period, res_timeout) at 0.
REQ-033 Reset asserted mid-measurement SHALL discard the measurement; no res_valid after release until a new grant completes.

Verification
REQ-034 Ch0 ref at 1 kHz (period 100000 cycles), meas lagging 25000 cycles, ch_req=0001, res_ready=1 -> res_ch=0, res_delay=25000, res_period=100000, res_timeout=0.
REQ-035 ch_req=1011 held, res_ready=1 -> successive grants 0,1,3,0; ch_grant always one-hot.
REQ-036 TIMEOUT=1000, ch2 granted, no ref edges -> res_valid with res_timeout=1, res_delay=0, res_period=0, 1000 cycles after grant.
REQ-037 res_ready low for 50 cycles in DONE -> all res_* outputs stable, busy=1, no new grant until the handshake.
REQ-038 ref and meas driven by the same edge -> res_delay=0; meas absent for one period -> res_delay=res_period.
REQ-039 rstn pulsed low in MEAS -> all outputs 0 immediately; the next request is granted to ch0 first.
